// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST scheduler: FSM encoding, default
// slot/watchdog sizing and the release hold length.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        LAUNCH  = 3'd2,
        RUN     = 3'd3,
        RELEASE = 3'd4,
        DONE_S  = 3'd5
    } bist_state_t;

    localparam int NSLOT_DEF   = 4;
    localparam int TIMEOUT_DEF = 200;
    // Cycles START stays low so the controller settles in its restartable wait state.
    localparam int RELEASE_CYC = 2;

endpackage

// File: rtl/bist_slot_pick.sv
// Lowest-set-bit priority encoder: picks the next pending slot to test.
module bist_slot_pick #(
    parameter int NSLOT  = 4,
    parameter int SLOT_W = 2
) (
    input  logic [NSLOT-1:0]  pend,
    output logic [SLOT_W-1:0] idx,
    output logic              any
);

    // Scan downwards so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = SLOT_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bist_scheduler.sv
// Runs one shared BIST controller over each enabled CUT slot in ascending
// order, collecting per-slot signature verdicts under a per-session watchdog.
module bist_scheduler
    import bist_pkg::*;
#(
    parameter int NSLOT   = NSLOT_DEF,
    parameter int SLOT_W  = 2,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              GO,
    input  logic [NSLOT-1:0]  SLOT_EN,
    input  logic              INIT,
    input  logic              FINISH,
    input  logic              BIST_END,
    input  logic              SIG_OK,
    output logic              BIST_START,
    output logic [SLOT_W-1:0] SEL,
    output logic              BUSY,
    output logic              DONE,
    output logic [NSLOT-1:0]  PASS_MAP,
    output logic              FAIL_ANY,
    output logic              TIMEOUT_ERR,
    output logic [2:0]        STATE_DBG
);

    bist_state_t       state_q, state_d;
    logic [NSLOT-1:0]  pend_q, en_q, pass_q;
    logic [SLOT_W-1:0] sel_q;
    logic [TO_W-1:0]   wdog_q;
    logic [1:0]        rel_q;
    logic              fail_q, to_q;
    logic [SLOT_W-1:0] pick_idx;
    logic              pick_any;
    logic              wdog_exp, to_hit, fin_hit;
    logic              unused_bist_end;

    // BIST_END is observed by the bench/top only; nothing here depends on it.
    assign unused_bist_end = BIST_END;

    bist_slot_pick #(.NSLOT(NSLOT), .SLOT_W(SLOT_W)) u_pick (
        .pend (pend_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // wdog_q holds the number of LAUNCH/RUN cycles already completed this session.
    assign wdog_exp = (wdog_q == TO_W'(TIMEOUT - 1));
    assign fin_hit  = (state_q == RUN) && FINISH;
    assign to_hit   = ((state_q == LAUNCH) || (state_q == RUN)) && (state_d == DONE_S);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (GO) state_d = (SLOT_EN == '0) ? DONE_S : SCAN;
            SCAN:    state_d = pick_any ? LAUNCH : DONE_S;
            LAUNCH: begin
                if (wdog_exp)  state_d = DONE_S;
                else if (INIT) state_d = RUN;
            end
            RUN: begin
                if (FINISH)        state_d = RELEASE;
                else if (wdog_exp) state_d = DONE_S;
            end
            RELEASE: if (rel_q == 2'(RELEASE_CYC - 1)) state_d = SCAN;
            DONE_S:  if (!GO) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            pend_q  <= '0;
            en_q    <= '0;
            pass_q  <= '0;
            sel_q   <= '0;
            wdog_q  <= '0;
            rel_q   <= '0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && GO) begin
                pend_q <= SLOT_EN;
                en_q   <= SLOT_EN;
                pass_q <= '0;
                to_q   <= 1'b0;
                fail_q <= 1'b0;
            end

            if (state_q == SCAN && pick_any) sel_q <= pick_idx;

            if (state_q == LAUNCH && INIT && !wdog_exp) pend_q[sel_q] <= 1'b0;

            if (state_q == SCAN) begin
                wdog_q <= '0;
            end else if ((state_q == LAUNCH || state_q == RUN) && (wdog_q != {TO_W{1'b1}})) begin
                wdog_q <= wdog_q + 1'b1;
            end

            if (state_q == RELEASE) rel_q <= rel_q + 1'b1;
            else                    rel_q <= '0;

            if (fin_hit) pass_q[sel_q] <= SIG_OK;

            if (to_hit) begin
                pass_q[sel_q] <= 1'b0;
                to_q          <= 1'b1;
            end

            // Summary verdict is taken once, on the way into DONE_S.
            if (state_d == DONE_S && state_q != DONE_S) begin
                fail_q <= to_hit || ((state_q == SCAN) && ((en_q & ~pass_q) != '0));
            end
        end
    end

    assign BIST_START  = (state_q == LAUNCH) || (state_q == RUN);
    assign BUSY        = (state_q == SCAN) || (state_q == LAUNCH) ||
                         (state_q == RUN)  || (state_q == RELEASE);
    assign DONE        = (state_q == DONE_S);
    assign SEL         = sel_q;
    assign PASS_MAP    = pass_q;
    assign FAIL_ANY    = fail_q;
    assign TIMEOUT_ERR = to_q;
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_bist_scheduler.sv
// Randomized bench for bist_scheduler: a behavioural BIST controller plus a
// slot-order scoreboard and a per-pass result model.
module tb_bist_scheduler;

    localparam int NSLOT   = 4;
    localparam int SLOT_W  = 2;
    localparam int TIMEOUT = 200;

    logic              CLK;
    logic              RESET;
    logic              GO;
    logic [NSLOT-1:0]  SLOT_EN;
    logic              INIT;
    logic              FINISH;
    logic              BIST_END;
    logic              SIG_OK;
    logic              BIST_START;
    logic [SLOT_W-1:0] SEL;
    logic              BUSY;
    logic              DONE;
    logic [NSLOT-1:0]  PASS_MAP;
    logic              FAIL_ANY;
    logic              TIMEOUT_ERR;
    logic [2:0]        STATE_DBG;

    bist_scheduler #(.NSLOT(NSLOT), .SLOT_W(SLOT_W), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .GO          (GO),
        .SLOT_EN     (SLOT_EN),
        .INIT        (INIT),
        .FINISH      (FINISH),
        .BIST_END    (BIST_END),
        .SIG_OK      (SIG_OK),
        .BIST_START  (BIST_START),
        .SEL         (SEL),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .PASS_MAP    (PASS_MAP),
        .FAIL_ANY    (FAIL_ANY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .STATE_DBG   (STATE_DBG)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- scoreboard / controller model ----------------
    logic [SLOT_W-1:0] exp_q[$];
    int                exp_launch_cyc = 0;
    int                ctl_n = 9, ctl_m = 9, ctl_hang = -1, ctl_fin_at = -1;
    logic [NSLOT-1:0]  ctl_ok = '1;
    int                ses_cnt = 0;
    logic              start_d = 1'b0;
    logic [SLOT_W-1:0] cur_sel = '0;

    function automatic int exp_len(input logic [SLOT_W-1:0] s);
        if (int'(s) == ctl_hang) return TIMEOUT;
        if (ctl_fin_at >= 0)     return ctl_fin_at + 1;
        return ctl_n + ctl_m + 1;
    endfunction

    // Controller: INIT ctl_n cycles after START rises, FINISH ctl_m cycles later.
    always @(negedge CLK) begin
        INIT   = 1'b0;
        FINISH = 1'b0;
        SIG_OK = 1'b0;
        if (RESET) begin
            start_d = 1'b0;
        end else begin
            if (BIST_START) begin
                if (!start_d) begin
                    ses_cnt = 0;
                    if (exp_q.size() == 0) begin
                        check("launch_unexpected", 32'(SEL), 32'hFFFF);
                        cur_sel = SEL;
                    end else begin
                        cur_sel = exp_q.pop_front();
                        check("launch_sel", 32'(SEL), 32'(cur_sel));
                    end
                    check("launch_cycle", 32'(cyc), 32'(exp_launch_cyc));
                end else begin
                    ses_cnt++;
                end
                if (ses_cnt == ctl_n) INIT = 1'b1;
                if (int'(cur_sel) != ctl_hang &&
                    ((ctl_fin_at >= 0) ? (ses_cnt == ctl_fin_at) : (ses_cnt == ctl_n + ctl_m))) begin
                    FINISH = 1'b1;
                    SIG_OK = ctl_ok[cur_sel];
                    exp_launch_cyc = cyc + 4;
                    check("sel_stable", 32'(SEL), 32'(cur_sel));
                end
            end else if (start_d) begin
                check("session_len", 32'(ses_cnt + 1), 32'(exp_len(cur_sel)));
                if (int'(cur_sel) == ctl_hang) check("done_after_abort", 32'(DONE), 32'd1);
            end
            start_d = BIST_START;
        end
    end

    // ---------------- driver ----------------
    task automatic run_pass(input logic [NSLOT-1:0] en, input logic [NSLOT-1:0] ok,
                            input int n, input int m, input int hang, input int fin_at,
                            input bit drop_go);
        logic [NSLOT-1:0] exp_pass;
        logic             exp_to, exp_fail;
        int               go_cyc;
        int               k;

        // Reference: slots visited in ascending order, stop at the hung slot.
        exp_pass = '0;
        exp_to   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NSLOT; i++) begin
            if (en[i] && !exp_to) begin
                exp_q.push_back(SLOT_W'(i));
                if (i == hang) exp_to = 1'b1;
                else           exp_pass[i] = ok[i];
            end
        end
        exp_fail = exp_to || ((en & ~exp_pass) != '0);

        ctl_n = n; ctl_m = m; ctl_hang = hang; ctl_fin_at = fin_at; ctl_ok = ok;

        @(negedge CLK);
        SLOT_EN        = en;
        GO             = 1'b1;
        go_cyc         = cyc;
        exp_launch_cyc = cyc + 2;
        @(negedge CLK);
        check("busy_after_go", 32'(BUSY), 32'(en != '0));
        SLOT_EN = NSLOT'($urandom);

        k = 0;
        while (!DONE && k < 5000) begin
            if (drop_go && k == 3) GO = 1'b0;
            @(negedge CLK);
            k++;
        end
        check("done_seen", 32'(DONE), 32'd1);
        if (en == '0) check("empty_done_latency", 32'((cyc - go_cyc) <= 2), 32'd1);
        check("busy_in_done", 32'(BUSY), 32'd0);
        check("start_in_done", 32'(BIST_START), 32'd0);
        check("pass_map", 32'(PASS_MAP), 32'(exp_pass));
        check("fail_any", 32'(FAIL_ANY), 32'(exp_fail));
        check("timeout_err", 32'(TIMEOUT_ERR), 32'(exp_to));
        check("slots_left", 32'(exp_q.size()), 32'd0);

        if (!drop_go) begin
            repeat (3) @(negedge CLK);
            check("hold_done", 32'(DONE), 32'd1);
            check("hold_no_restart", 32'(BUSY | BIST_START), 32'd0);
            GO = 1'b0;
        end
        @(negedge CLK);
        check("back_idle", 32'(STATE_DBG), 32'd0);
        check("results_held", 32'({PASS_MAP, FAIL_ANY, TIMEOUT_ERR}), 32'({exp_pass, exp_fail, exp_to}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET = 1'b1; GO = 1'b0; SLOT_EN = '0; BIST_END = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", 32'({BIST_START, SEL, BUSY, DONE, PASS_MAP, FAIL_ANY, TIMEOUT_ERR}), 32'd0);
        check("reset_state", 32'(STATE_DBG), 32'd0);
        RESET = 1'b0;

        run_pass(4'b1111, 4'b1111, 9, 9, -1, -1, 1'b0);          // full pass
        run_pass(4'b1010, 4'b0111, 9, 9, -1, -1, 1'b0);          // sparse, slot 3 bad
        run_pass(4'b0000, 4'b1111, 9, 9, -1, -1, 1'b0);          // empty
        run_pass(4'b0011, 4'b1111, 3, 5, 0, -1, 1'b0);           // watchdog abort
        run_pass(4'b0101, 4'b1111, 3, 5, -1, TIMEOUT - 1, 1'b0); // FINISH on expiry cycle
        run_pass(4'b0110, 4'b0100, 2, 4, -1, -1, 1'b1);          // GO dropped mid-pass

        for (int r = 0; r < 6; r++) begin
            run_pass(NSLOT'($urandom_range(1, 15)), NSLOT'($urandom_range(0, 15)),
                     $urandom_range(1, 12), $urandom_range(1, 12), -1, -1, bit'(r % 2));
        end
        run_pass(4'b1111, NSLOT'($urandom_range(0, 15)), 2, 3, $urandom_range(0, 3), -1, 1'b0);

        // Asynchronous reset in the middle of slot 3's RUN phase.
        ctl_n = 3; ctl_m = 8; ctl_hang = -1; ctl_fin_at = -1; ctl_ok = '1;
        exp_q.delete();
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        @(negedge CLK);
        SLOT_EN = 4'b1100; GO = 1'b1; exp_launch_cyc = cyc + 2;
        repeat (25) @(negedge CLK);
        check("pre_reset_run", 32'(STATE_DBG), 32'd3);
        check("pre_reset_sel", 32'(SEL), 32'd3);
        check("pre_reset_map", 32'(PASS_MAP), 32'b0100);
        #2 RESET = 1'b1; GO = 1'b0;
        #1;
        check("async_reset_outputs", 32'({BIST_START, SEL, BUSY, DONE, PASS_MAP, FAIL_ANY, TIMEOUT_ERR}), 32'd0);
        check("async_reset_state", 32'(STATE_DBG), 32'd0);
        exp_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        run_pass(4'b1111, NSLOT'($urandom_range(0, 15)), 4, 6, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
